// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/write-back
// and halts on illegal instructions, syscall, or a memory request that is never acknowledged.
module mips_multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       alu_zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_write_en,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic       alu_src_b,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       halted,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_START  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR
    } cls_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_LUI = 3'd6;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    cls_t          cls_q, dec_cls;
    logic [2:0]    op_q, dec_op;
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;

    // Unlisted encodings (including syscall) leave dec_cls at C_NONE, which halts.
    always_comb begin
        dec_cls = C_NONE;
        dec_op  = OP_ADD;
        if (opcode == 6'h00) begin
            case (func)
                6'h20:   begin dec_cls = C_RALU; dec_op = OP_ADD; end
                6'h22:   begin dec_cls = C_RALU; dec_op = OP_SUB; end
                6'h24:   begin dec_cls = C_RALU; dec_op = OP_AND; end
                6'h25:   begin dec_cls = C_RALU; dec_op = OP_OR;  end
                6'h2A:   begin dec_cls = C_RALU; dec_op = OP_SLT; end
                6'h00:   begin dec_cls = C_RALU; dec_op = OP_SLL; end
                6'h08:   dec_cls = C_JR;
                default: dec_cls = C_NONE;
            endcase
        end else begin
            case (opcode)
                6'h08:   begin dec_cls = C_IALU; dec_op = OP_ADD; end
                6'h0C:   begin dec_cls = C_IALU; dec_op = OP_AND; end
                6'h0D:   begin dec_cls = C_IALU; dec_op = OP_OR;  end
                6'h0F:   begin dec_cls = C_IALU; dec_op = OP_LUI; end
                6'h23:   dec_cls = C_LW;
                6'h2B:   dec_cls = C_SW;
                6'h04:   begin dec_cls = C_BEQ; dec_op = OP_SUB; end
                6'h05:   begin dec_cls = C_BNE; dec_op = OP_SUB; end
                6'h02:   dec_cls = C_J;
                6'h03:   dec_cls = C_JAL;
                default: dec_cls = C_NONE;
            endcase
        end
    end

    // An acknowledge arriving on the timeout edge still completes the access.
    assign timeout_hit = (wait_cnt == WAIT_LAST) && !mem_ack;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q  <= S_START;
            cls_q    <= C_NONE;
            op_q     <= OP_ADD;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q <= dec_cls;
                op_q  <= dec_op;
            end
            if (mem_req && !mem_ack && !timeout_hit)
                wait_cnt <= wait_cnt + CW'(1);
            else
                wait_cnt <= '0;
        end
    end

    // NOTE: every output and state_d gets a default first so no path through
    // the case leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_write_en = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        alu_op       = 3'd0;
        alu_src_b    = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 2'd0;
        mem_to_reg   = 2'd0;
        halted       = 1'b0;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: state_d = (dec_cls == C_NONE) ? S_HALT : S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                case (cls_q)
                    C_RALU: begin alu_op = op_q; state_d = S_WB; end
                    C_IALU: begin alu_op = op_q; alu_src_b = 1'b1; state_d = S_WB; end
                    C_LW, C_SW: begin alu_op = OP_ADD; alu_src_b = 1'b1; state_d = S_MEM; end
                    C_BEQ, C_BNE: begin
                        alu_op   = OP_SUB;
                        pc_src   = 2'd1;
                        pc_write = (cls_q == C_BEQ) ? alu_zero : !alu_zero;
                    end
                    C_J: begin pc_write = 1'b1; pc_src = 2'd2; end
                    C_JAL: begin
                        pc_write   = 1'b1;
                        pc_src     = 2'd2;
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                    C_JR: begin pc_write = 1'b1; pc_src = 2'd3; end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                alu_op       = OP_ADD;
                alu_src_b    = 1'b1;
                mem_req      = 1'b1;
                mem_write_en = (cls_q == C_SW);
                if (mem_ack)
                    state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
                else if (timeout_hit)
                    state_d = S_HALT;
            end
            S_WB: begin
                state_d   = S_FETCH;
                reg_write = 1'b1;
                alu_op    = op_q;
                alu_src_b = (cls_q == C_IALU) || (cls_q == C_LW);
                if (cls_q == C_RALU)
                    reg_dst = 2'd1;
                else if (cls_q == C_LW)
                    mem_to_reg = 2'd1;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_HALT;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle expected snapshots are queued
// as stimulus is driven and compared against the DUT outputs on the falling edge.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [5:0] opcode, func;
    logic       alu_zero, mem_ack;
    logic       mem_req, mem_write_en, ir_write, pc_write, alu_src_b, reg_write, halted;
    logic [1:0] pc_src, reg_dst, mem_to_reg;
    logic [2:0] alu_op, state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       hlt;
        logic       mreq;
        logic       mwe;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic [2:0] aop;
        logic       asb;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] m2r;
    } snap_t;

    snap_t sb[$];      // scoreboard of expected per-cycle snapshots
    snap_t ev[$];      // per-scenario expectation table
    logic  av[$];      // per-scenario mem_ack table

    mips_multicycle_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_b(rst_b), .opcode(opcode), .func(func),
        .alu_zero(alu_zero), .mem_ack(mem_ack), .mem_req(mem_req),
        .mem_write_en(mem_write_en), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_op(alu_op), .alu_src_b(alu_src_b),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(input logic [2:0] st, input logic mreq = 1'b0,
                                 input logic mwe = 1'b0, input logic irw = 1'b0,
                                 input logic pcw = 1'b0, input logic [1:0] pcs = 2'd0,
                                 input logic [2:0] aop = 3'd0, input logic asb = 1'b0,
                                 input logic rw = 1'b0, input logic [1:0] rd = 2'd0,
                                 input logic [1:0] m2r = 2'd0);
        snap_t s;
        s.st = st; s.hlt = (st == 3'd5); s.mreq = mreq; s.mwe = mwe; s.irw = irw;
        s.pcw = pcw; s.pcs = pcs; s.aop = aop; s.asb = asb; s.rw = rw; s.rd = rd;
        s.m2r = m2r;
        return s;
    endfunction

    function automatic snap_t observe();
        snap_t s;
        s.st = state; s.hlt = halted; s.mreq = mem_req; s.mwe = mem_write_en;
        s.irw = ir_write; s.pcw = pc_write; s.pcs = pc_src; s.aop = alu_op;
        s.asb = alu_src_b; s.rw = reg_write; s.rd = reg_dst; s.m2r = mem_to_reg;
        return s;
    endfunction

    task automatic step(input snap_t e, input logic a);
        ev.push_back(e);
        av.push_back(a);
    endtask

    // Hold reset across one rising edge, release just after it: the next cycle is START.
    task automatic reset_dut();
        rst_b   = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        #1 rst_b = 1'b0;
        ev.delete();
        av.delete();
    endtask

    task automatic test_reset();
        snap_t got, want;
        opcode = 6'h00; func = 6'h20; alu_zero = 1'b0; mem_ack = 1'b1;
        rst_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sb.push_back(mk(3'd7));
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset[%0d]: got %h expected %h", i, got, want);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_r_alu();
        snap_t got, want;
        reset_dut();
        opcode = 6'h00; func = 6'h20;
        step(mk(3'd7), 1'b1);
        step(mk(3'd0, 1, 0, 1, 1), 1'b1);
        step(mk(3'd1), 1'b1);
        step(mk(3'd2, 0, 0, 0, 0, 2'd0, 3'd0, 0), 1'b1);
        step(mk(3'd4, 0, 0, 0, 0, 2'd0, 3'd0, 0, 1, 2'd1, 2'd0), 1'b1);
        step(mk(3'd0, 1, 0, 1, 1), 1'b1);
        for (int i = 0; i < ev.size(); i++) begin
            mem_ack = av[i]; sb.push_back(ev[i]);
            @(negedge clk);
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL add[%0d]: got %h expected %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_i_alu();
        snap_t got, want;
        reset_dut();
        opcode = 6'h0D; func = 6'h3F;
        step(mk(3'd7), 1'b0);
        step(mk(3'd0, 1, 0, 1, 1), 1'b1);
        step(mk(3'd1), 1'b0);
        step(mk(3'd2, 0, 0, 0, 0, 2'd0, 3'd3, 1), 1'b1);
        step(mk(3'd4, 0, 0, 0, 0, 2'd0, 3'd3, 1, 1, 2'd0, 2'd0), 1'b1);
        step(mk(3'd0, 1), 1'b0);
        for (int i = 0; i < ev.size(); i++) begin
            mem_ack = av[i]; sb.push_back(ev[i]);
            @(negedge clk);
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL ori[%0d]: got %h expected %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_sw();
        snap_t got, want;
        reset_dut();
        opcode = 6'h23; func = 6'h00;
        step(mk(3'd7), 1'b0);
        step(mk(3'd0, 1, 0, 1, 1), 1'b1);
        step(mk(3'd1), 1'b1);
        step(mk(3'd2, 0, 0, 0, 0, 2'd0, 3'd0, 1), 1'b1);
        for (int k = 0; k < 3; k++) step(mk(3'd3, 1, 0, 0, 0, 2'd0, 3'd0, 1), 1'b0);
        step(mk(3'd3, 1, 0, 0, 0, 2'd0, 3'd0, 1), 1'b1);
        step(mk(3'd4, 0, 0, 0, 0, 2'd0, 3'd0, 1, 1, 2'd0, 2'd1), 1'b1);
        step(mk(3'd0, 1), 1'b0);
        for (int i = 0; i < ev.size(); i++) begin
            mem_ack = av[i]; sb.push_back(ev[i]);
            @(negedge clk);
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL lw[%0d]: got %h expected %h", i, got, want);
            end
            @(posedge clk); #1;
        end
        reset_dut();
        opcode = 6'h2B;
        step(mk(3'd7), 1'b0);
        step(mk(3'd0, 1, 0, 1, 1), 1'b1);
        step(mk(3'd1), 1'b0);
        step(mk(3'd2, 0, 0, 0, 0, 2'd0, 3'd0, 1), 1'b0);
        step(mk(3'd3, 1, 1, 0, 0, 2'd0, 3'd0, 1), 1'b1);
        step(mk(3'd0, 1), 1'b0);
        for (int i = 0; i < ev.size(); i++) begin
            mem_ack = av[i]; sb.push_back(ev[i]);
            @(negedge clk);
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL sw[%0d]: got %h expected %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        snap_t got, want;
        logic [5:0] ops[4]  = '{6'h04, 6'h04, 6'h03, 6'h00};
        logic [5:0] fns[4]  = '{6'h00, 6'h00, 6'h00, 6'h08};
        logic       zs[4]   = '{1'b1, 1'b0, 1'b0, 1'b0};
        snap_t      exs[4];
        exs[0] = mk(3'd2, 0, 0, 0, 1, 2'd1, 3'd1, 0);
        exs[1] = mk(3'd2, 0, 0, 0, 0, 2'd1, 3'd1, 0);
        exs[2] = mk(3'd2, 0, 0, 0, 1, 2'd2, 3'd0, 0, 1, 2'd2, 2'd2);
        exs[3] = mk(3'd2, 0, 0, 0, 1, 2'd3);
        for (int t = 0; t < 4; t++) begin
            reset_dut();
            opcode = ops[t]; func = fns[t]; alu_zero = zs[t];
            step(mk(3'd7), 1'b1);
            step(mk(3'd0, 1, 0, 1, 1), 1'b1);
            step(mk(3'd1), 1'b0);
            step(exs[t], 1'b1);
            step(mk(3'd0, 1), 1'b0);
            for (int i = 0; i < ev.size(); i++) begin
                mem_ack = av[i]; sb.push_back(ev[i]);
                @(negedge clk);
                got = observe(); want = sb.pop_front(); checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL branch_jump%0d[%0d]: got %h expected %h", t, i, got, want);
                end
                @(posedge clk); #1;
            end
        end
        alu_zero = 1'b0;
    endtask

    task automatic test_illegal();
        snap_t got, want;
        logic [5:0] ops[2] = '{6'h3F, 6'h00};
        logic [5:0] fns[2] = '{6'h20, 6'h0C};
        for (int t = 0; t < 2; t++) begin
            reset_dut();
            opcode = ops[t]; func = fns[t];
            step(mk(3'd7), 1'b0);
            step(mk(3'd0, 1, 0, 1, 1), 1'b1);
            step(mk(3'd1), 1'b1);
            for (int k = 0; k < 3; k++) step(mk(3'd5), 1'b1);
            for (int i = 0; i < ev.size(); i++) begin
                mem_ack = av[i]; sb.push_back(ev[i]);
                @(negedge clk);
                got = observe(); want = sb.pop_front(); checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL illegal%0d[%0d]: got %h expected %h", t, i, got, want);
                end
                @(posedge clk); #1;
            end
            @(negedge clk); #1;
            rst_b = 1'b1;
            #1;
            sb.push_back(mk(3'd7));
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL illegal%0d_reset: got %h expected %h", t, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        snap_t got, want;
        for (int t = 0; t < 2; t++) begin
            reset_dut();
            opcode = 6'h00; func = 6'h20;
            step(mk(3'd7), 1'b0);
            for (int k = 0; k < 15; k++) step(mk(3'd0, 1), 1'b0);
            if (t == 0) begin
                step(mk(3'd0, 1), 1'b0);
                step(mk(3'd5), 1'b0);
                step(mk(3'd5), 1'b1);
            end else begin
                step(mk(3'd0, 1, 0, 1, 1), 1'b1);
                step(mk(3'd1), 1'b0);
            end
            for (int i = 0; i < ev.size(); i++) begin
                mem_ack = av[i]; sb.push_back(ev[i]);
                @(negedge clk);
                got = observe(); want = sb.pop_front(); checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL timeout%0d[%0d]: got %h expected %h", t, i, got, want);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid_sw();
        snap_t got, want;
        reset_dut();
        opcode = 6'h2B; func = 6'h00;
        step(mk(3'd7), 1'b0);
        step(mk(3'd0, 1, 0, 1, 1), 1'b1);
        step(mk(3'd1), 1'b0);
        step(mk(3'd2, 0, 0, 0, 0, 2'd0, 3'd0, 1), 1'b0);
        step(mk(3'd3, 1, 1, 0, 0, 2'd0, 3'd0, 1), 1'b0);
        for (int i = 0; i < ev.size(); i++) begin
            mem_ack = av[i]; sb.push_back(ev[i]);
            @(negedge clk);
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL sw_pre_reset[%0d]: got %h expected %h", i, got, want);
            end
            if (i < ev.size() - 1) begin
                @(posedge clk); #1;
            end
        end
        #1 rst_b = 1'b1;
        #1;
        sb.push_back(mk(3'd7));
        got = observe(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL sw_async_reset: got %h expected %h", got, want);
        end
        @(posedge clk); #1 rst_b = 1'b0;
        sb.push_back(mk(3'd7));
        sb.push_back(mk(3'd0, 1));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL sw_after_reset[%0d]: got %h expected %h", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_r_alu();
        test_i_alu();
        test_lw_sw();
        test_branch_jump();
        test_illegal();
        test_timeout();
        test_reset_mid_sw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: the number of consecutive unacknowledged mem_req cycles that forces HALT.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_b, input, 1 bit: asynchronous active-high reset; asserted = 1.
REQ-004 SHALL have port opcode, input, 6 bits: instruction[31:26] from the datapath IR.
REQ-005 SHALL have port func, input, 6 bits: instruction[5:0] from the datapath IR.
REQ-006 SHALL have port alu_zero, input, 1 bit: ALU result == 0.
REQ-007 SHALL have port mem_ack, input, 1 bit: memory has completed the current request.
REQ-008 SHALL have port mem_req, output, 1 bit: memory access request.
REQ-009 SHALL have port mem_write_en, output, 1 bit: the current request is a write.
REQ-010 SHALL have port ir_write, output, 1 bit: load IR.
REQ-011 SHALL have port pc_write, output, 1 bit: load PC.
REQ-012 SHALL have port pc_src, output, 2 bits: PC source; 0 = pc+4, 1 = branch target, 2 = jump target, 3 = rs.
REQ-013 SHALL have port alu_op, output, 3 bits: ALU operation; 0 = ADD, 1 = SUB, 2 = AND, 3 = OR, 4 = SLT, 5 = SLL, 6 = LUI.
REQ-014 SHALL have port alu_src_b, output, 1 bit: ALU B operand; 0 = rt, 1 = immediate.
REQ-015 SHALL have port reg_write, reg_dst and mem_to_reg, outputs of 1, 2 and 2 bits: register-file write enable; destination (0 = rt, 1 = rd, 2 = r31); write data (0 = ALU, 1 = memory, 2 = PC).
REQ-016 SHALL have port halted, output, 1 bit: core stopped.
REQ-017 SHALL have port state, output, 3 bits: debug view of the current state.

Function
REQ-018 SHALL implement the states START = 7, FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4 and HALT = 5; any other encoding SHALL go to HALT.
REQ-019 SHALL drive every output to 0 by default; each state below asserts only the outputs it lists.
REQ-020 SHALL move from START to FETCH on the next edge.
REQ-021 FETCH SHALL assert mem_req=1; in the cycle mem_ack=1 it SHALL assert ir_write=1, pc_write=1, pc_src=0 and then go to DECODE; without mem_ack it SHALL stay in FETCH.
REQ-022 DECODE SHALL classify opcode/func, latch the class and ALU op, and go to EXEC; an unlisted opcode, or an unlisted func when opcode=0, SHALL go to HALT.
REQ-023 SHALL decode R-type (opcode 0) func values as: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL, 0x08 JR, 0x0C SYSCALL (DECODE goes to HALT).
REQ-024 SHALL decode I/J-type opcodes as: 0x08 addi (ADD), 0x0C andi (AND), 0x0D ori (OR), 0x0F lui (LUI), 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x02 j, 0x03 jal.
REQ-025 EXEC for R-ALU SHALL drive alu_op from func with alu_src_b=0, then go to WB.
REQ-026 EXEC for I-ALU SHALL drive alu_op from opcode with alu_src_b=1, then go to WB.
REQ-027 EXEC for lw/sw SHALL drive alu_op=ADD, alu_src_b=1, then go to MEM.
REQ-028 EXEC for beq/bne SHALL drive alu_op=SUB, alu_src_b=0, pc_src=1, and pc_write=(beq&alu_zero)|(bne&!alu_zero), then go to FETCH.
REQ-029 EXEC for j SHALL drive pc_write=1, pc_src=2; jal additionally SHALL drive reg_write=1, reg_dst=2, mem_to_reg=2 in the same cycle; jr SHALL drive pc_write=1, pc_src=3; all three then go to FETCH.
REQ-030 MEM SHALL hold alu_op=ADD, alu_src_b=1, mem_req=1, and mem_write_en=1 for sw; on mem_ack it SHALL go to WB for lw or FETCH for sw.
REQ-031 WB SHALL drive reg_write=1 with reg_dst=1, mem_to_reg=0 for R-ALU; reg_dst=0, mem_to_reg=0 for I-ALU; reg_dst=0, mem_to_reg=1 for lw; it SHALL keep the latched alu_op/alu_src_b and then go to FETCH.
REQ-032 SHALL give, with mem_ack=1 at the first request cycle, latencies of: R/I-ALU 4 cycles, lw 5, sw 4, branch/jump 3.
REQ-033 SHALL keep a wait counter that increments each cycle mem_req=1 and mem_ack=0, and clears on mem_ack or on leaving FETCH/MEM.
REQ-034 SHALL go to HALT on the edge where the wait counter reaches TIMEOUT-1 with mem_ack=0 still low.
REQ-035 HALT SHALL be sticky until reset, with halted=1 and every strobe 0.
REQ-036 SHALL ignore mem_ack outside FETCH/MEM.
REQ-037 SHALL, when mem_ack arrives in the same cycle as the timeout edge, treat mem_ack as winning.

Reset
REQ-038 SHALL, while rst_b=1 (asynchronously), force state=START, wait counter=0, latched class/ALU op=0, and all outputs 0 including halted; this applies mid-instruction and in HALT.
REQ-039 SHALL enter FETCH on the first edge after rst_b falls, with no partial writes of the aborted instruction.

Verification
REQ-040 SHALL verify: reset, then add (opcode 0, func 0x20) with mem_ack=1 each request -> states 7,0,1,2,4,0; reg_write=1, reg_dst=1 only in WB.
REQ-041 SHALL verify: lw with mem_ack delayed 3 cycles in MEM -> MEM held 4 cycles, mem_req=1, mem_write_en=0, then WB with mem_to_reg=1.
REQ-042 SHALL verify: beq with alu_zero=1, then with alu_zero=0 -> pc_write=1, pc_src=1 in EXEC for the first only; both return to FETCH after 3 cycles.
REQ-043 SHALL verify: opcode 0x3F, and separately syscall -> HALT after DECODE with halted=1 sticky; rst_b pulse -> START.
REQ-044 SHALL verify: mem_ack held 0 in FETCH with TIMEOUT=16 -> HALT after 16 mem_req cycles; a repeat with mem_ack=1 on cycle 16 -> DECODE instead.
REQ-045 SHALL verify: rst_b asserted mid-MEM of sw -> mem_req, mem_write_en and state drop immediately (asynchronously); FETCH follows one edge after release.
